// File: rtl/onchip_ram_pipelined.sv
// rtl/onchip_ram_pipelined.sv - single-port on-chip RAM with Avalon-MM pipelined slave interface
//
// Purpose: parametrised word-addressed RAM. Optional output register
// (read latency 1 or 2), out-of-range address handling and optional
// zero-fill of every word after reset.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   address, byteenable,         Avalon-MM request (word address, byte lanes,
//   chipselect, read, write,     select, read/write strobes, write data)
//   writedata
//   clken                        clock enable; 0 freezes the whole block
//   readdata, readdatavalid      read response (one strobe per accepted read)
//   waitrequest                  1 = request not accepted this cycle
//   init_done                    1 once zero-fill has completed
module onchip_ram_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 13,
  parameter int DEPTH          = 5120,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_done
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);
  // DEPTH may equal 2^ADDR_WIDTH, so compare with one extra bit.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    init_q;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  logic                    rd1_valid;
  logic [DATA_WIDTH-1:0]   rd1_data;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;

  logic running, in_range, acc, acc_wr, acc_rd;

  assign running  = (state == RUN);
  assign in_range = ({1'b0, address} < DEPTH_EXT);
  assign acc      = running & clken & chipselect & (read | write);
  // Simultaneous read+write is a write only; it produces no response.
  assign acc_wr   = acc & write;
  assign acc_rd   = acc & read & ~write;

  // Storage: no reset so it maps onto block RAM. Writes are suppressed
  // while reset is held so a stray bus cycle cannot corrupt contents.
  always_ff @(posedge clk) begin
    if (reset_n && clken) begin
      if (!running) begin
        mem[cnt] <= '0;
      end else if (acc_wr && in_range) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (byteenable[i]) mem[address][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt       <= '0;
      init_q    <= (CLEAR_ON_RESET == 0);
      rd1_valid <= 1'b0;
      rd1_data  <= '0;
    end else if (clken) begin
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST_WORD) begin
          state  <= RUN;
          init_q <= 1'b1;
        end
      end
      rd1_valid <= acc_rd;
      if (acc_rd) rd1_data <= in_range ? mem[address] : '0;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  rd2_valid;
      logic [DATA_WIDTH-1:0] rd2_data;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd2_valid <= 1'b0;
          rd2_data  <= '0;
        end else if (clken) begin
          rd2_valid <= rd1_valid;
          rd2_data  <= rd1_data;
        end
      end
      assign out_valid = rd2_valid;
      assign out_data  = rd2_data;
    end else begin : g_no_out_reg
      assign out_valid = rd1_valid;
      assign out_data  = rd1_data;
    end
  endgenerate

  // The pending strobe is held in its register while clken=0 and only
  // presented when the block is enabled, so each read strobes exactly once.
  assign readdatavalid = out_valid & clken;
  assign readdata      = out_data;
  assign waitrequest   = reset_n ? (~running | ~clken) : (CLEAR_ON_RESET != 0);
  assign init_done     = init_q;

endmodule
